// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for the multicycle core. One shared ALU and one unified
// instruction/data memory are sequenced over several cycles per instruction.
// Outputs are Moore-style, decoded from the current state only. The one
// exception is pc_write/ir_write in FETCH, which are qualified by mem_ready so
// that PC and IR load only in the cycle the fetch actually completes.
//
// Memory handshake: a request (mem_read or mem_write) is held asserted for as
// long as the FSM sits in FETCH, MEMRD or MEMWR. mem_ready=1 in a cycle means
// the access completed in that cycle. The FSM advances on that same clock
// edge. mem_ready has no effect in any other state.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   op             opcode field of the IR, used in DECODE and MEMADR
//   mem_ready      memory access completed this cycle
//   pc_write       load PC from ALU result
//   pc_src         PC source: 0 = ALU result, 1 = ALUOut
//   branch         conditional PC write (gated by zero in the datapath)
//   ir_write       load IR from memory read data
//   iord           memory address: 0 = PC, 1 = ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   reg_write      register file write enable
//   reg_dst        destination register: 0 = rt, 1 = rd
//   mem_to_reg     writeback source: 0 = ALUOut, 1 = MDR
//   alu_src_a      ALU A: 0 = PC, 1 = A register
//   alu_src_b      ALU B: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
//   alu_op         00 = add, 01 = sub, 10 = funct
//   illegal_op     unsupported opcode decoded
//   instr_count    completed instruction fetches, wraps modulo 2^CNT_W
//   state_dbg      current state encoding (debug only)
// -----------------------------------------------------------------------------

package types;
    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_type;
endpackage

module multicycle_control
    import types::*;
#(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  opcode_type       op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             branch,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts completed fetches, i.e. every cycle ir_write is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (state == S_FETCH && mem_ready) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every cycle, but PC and IR load only on
                // the completing cycle so a stall leaves both untouched.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                // IR is not written after FETCH, so op is still LW or SW.
                state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                branch     = 1'b1;
                pc_src     = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                state_next = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Three instances share op and
// mem_ready:
//   m_*  default parameters, main sequence
//   w_*  CNT_W=4, same reset as m_*, for the counter wrap
//   h_*  ILLEGAL_HALT=1, own reset, held in reset until the halt test
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 time
// unit later. The output checks use a packed vector:
//   {pc_write, pc_src, branch, ir_write, iord, mem_read, mem_write, reg_write,
//    reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], illegal_op}
// -----------------------------------------------------------------------------

module tb_multicycle_control;
    import types::*;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_FETCH   = 4'd1;
    localparam logic [3:0] ST_DECODE  = 4'd2;
    localparam logic [3:0] ST_MEMADR  = 4'd3;
    localparam logic [3:0] ST_MEMRD   = 4'd4;
    localparam logic [3:0] ST_MEMWB   = 4'd5;
    localparam logic [3:0] ST_MEMWR   = 4'd6;
    localparam logic [3:0] ST_EXEC    = 4'd7;
    localparam logic [3:0] ST_ALUWB   = 4'd8;
    localparam logic [3:0] ST_BRANCH  = 4'd9;
    localparam logic [3:0] ST_ILLEGAL = 4'd10;

    // Expected output vectors, hand-derived from the per-state strobe list.
    localparam logic [15:0] O_NONE   = 16'h0000;
    localparam logic [15:0] O_FETCH  = 16'h9408; // pc_write ir_write mem_read b=01
    localparam logic [15:0] O_FSTALL = 16'h0408; // mem_read b=01
    localparam logic [15:0] O_DECODE = 16'h0018; // b=11
    localparam logic [15:0] O_MEMADR = 16'h0030; // a=1 b=10
    localparam logic [15:0] O_MEMRD  = 16'h0C00; // iord mem_read
    localparam logic [15:0] O_MEMWB  = 16'h0140; // reg_write mem_to_reg
    localparam logic [15:0] O_MEMWR  = 16'h0A00; // iord mem_write
    localparam logic [15:0] O_EXEC   = 16'h0024; // a=1 op=10
    localparam logic [15:0] O_ALUWB  = 16'h0180; // reg_write reg_dst
    localparam logic [15:0] O_BRANCH = 16'h6022; // pc_src branch a=1 op=01
    localparam logic [15:0] O_ILL    = 16'h0001; // illegal_op

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_halt = 1'b0;
    opcode_type op;
    logic       mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    // Main instance
    logic m_pc_write, m_pc_src, m_branch, m_ir_write, m_iord, m_mem_read;
    logic m_mem_write, m_reg_write, m_reg_dst, m_mem_to_reg, m_alu_src_a, m_illegal_op;
    logic [1:0]  m_alu_src_b, m_alu_op;
    logic [31:0] m_count;
    logic [3:0]  m_state;
    logic [15:0] m_outs;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(m_pc_write), .pc_src(m_pc_src), .branch(m_branch),
        .ir_write(m_ir_write), .iord(m_iord), .mem_read(m_mem_read),
        .mem_write(m_mem_write), .reg_write(m_reg_write), .reg_dst(m_reg_dst),
        .mem_to_reg(m_mem_to_reg), .alu_src_a(m_alu_src_a), .alu_src_b(m_alu_src_b),
        .alu_op(m_alu_op), .illegal_op(m_illegal_op), .instr_count(m_count),
        .state_dbg(m_state)
    );
    assign m_outs = {m_pc_write, m_pc_src, m_branch, m_ir_write, m_iord, m_mem_read,
                     m_mem_write, m_reg_write, m_reg_dst, m_mem_to_reg, m_alu_src_a,
                     m_alu_src_b, m_alu_op, m_illegal_op};

    // 4-bit counter instance
    logic w_pc_write, w_pc_src, w_branch, w_ir_write, w_iord, w_mem_read;
    logic w_mem_write, w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a, w_illegal_op;
    logic [1:0]  w_alu_src_b, w_alu_op;
    logic [3:0]  w_count;
    logic [3:0]  w_state;
    logic [15:0] w_outs;

    multicycle_control #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(w_pc_write), .pc_src(w_pc_src), .branch(w_branch),
        .ir_write(w_ir_write), .iord(w_iord), .mem_read(w_mem_read),
        .mem_write(w_mem_write), .reg_write(w_reg_write), .reg_dst(w_reg_dst),
        .mem_to_reg(w_mem_to_reg), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .alu_op(w_alu_op), .illegal_op(w_illegal_op), .instr_count(w_count),
        .state_dbg(w_state)
    );
    assign w_outs = {w_pc_write, w_pc_src, w_branch, w_ir_write, w_iord, w_mem_read,
                     w_mem_write, w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a,
                     w_alu_src_b, w_alu_op, w_illegal_op};

    // Halting instance
    logic h_pc_write, h_pc_src, h_branch, h_ir_write, h_iord, h_mem_read;
    logic h_mem_write, h_reg_write, h_reg_dst, h_mem_to_reg, h_alu_src_a, h_illegal_op;
    logic [1:0]  h_alu_src_b, h_alu_op;
    logic [31:0] h_count;
    logic [3:0]  h_state;
    logic [15:0] h_outs;

    multicycle_control #(.ILLEGAL_HALT(1'b1)) dut_halt (
        .clk(clk), .rst_n(rst_halt), .op(op), .mem_ready(mem_ready),
        .pc_write(h_pc_write), .pc_src(h_pc_src), .branch(h_branch),
        .ir_write(h_ir_write), .iord(h_iord), .mem_read(h_mem_read),
        .mem_write(h_mem_write), .reg_write(h_reg_write), .reg_dst(h_reg_dst),
        .mem_to_reg(h_mem_to_reg), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b),
        .alu_op(h_alu_op), .illegal_op(h_illegal_op), .instr_count(h_count),
        .state_dbg(h_state)
    );
    assign h_outs = {h_pc_write, h_pc_src, h_branch, h_ir_write, h_iord, h_mem_read,
                     h_mem_write, h_reg_write, h_reg_dst, h_mem_to_reg, h_alu_src_a,
                     h_alu_src_b, h_alu_op, h_illegal_op};

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe exclusivity, checked every cycle away from the clock edge
    always @(negedge clk) begin
        check("rd_wr_excl", {31'd0, m_mem_read & m_mem_write}, 32'd0);
        check("regwr_memwr_excl", {31'd0, m_reg_write & m_mem_write}, 32'd0);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m(input string tag, input logic [3:0] st, input logic [15:0] o);
        #1;
        check({tag, ".state"}, {28'd0, m_state}, {28'd0, st});
        check({tag, ".outs"}, {16'd0, m_outs}, {16'd0, o});
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [15:0] o);
        chk_m(tag, st, o);
        tick();
    endtask

    task automatic step_h(input string tag, input logic [3:0] st, input logic [15:0] o);
        #1;
        check({tag, ".state"}, {28'd0, h_state}, {28'd0, st});
        check({tag, ".outs"}, {16'd0, h_outs}, {16'd0, o});
        tick();
    endtask

    initial begin
        op        = OP_LW;
        mem_ready = 1'b1;

        // Reset state of all instances
        repeat (2) @(posedge clk);
        #1;
        chk_m("rst", ST_IDLE, O_NONE);
        check("rst.count", m_count, 32'd0);
        check("rst.w4_outs", {16'd0, w_outs}, 32'd0);
        check("rst.w4_state", {28'd0, w_state}, 32'd0);
        check("rst.w4_count", {28'd0, w_count}, 32'd0);
        check("rst.halt_outs", {16'd0, h_outs}, 32'd0);
        check("rst.halt_count", h_count, 32'd0);
        tick();
        rst_n = 1'b1;
        step("idle", ST_IDLE, O_NONE);

        // LW, zero wait
        op = OP_LW;
        step("lw.fetch", ST_FETCH, O_FETCH);
        check("lw.count", m_count, 32'd1);
        step("lw.decode", ST_DECODE, O_DECODE);
        step("lw.memadr", ST_MEMADR, O_MEMADR);
        step("lw.memrd", ST_MEMRD, O_MEMRD);
        step("lw.memwb", ST_MEMWB, O_MEMWB);

        // SW, three stall cycles in MEMWR
        op = OP_SW;
        step("sw.fetch", ST_FETCH, O_FETCH);
        check("sw.count", m_count, 32'd2);
        step("sw.decode", ST_DECODE, O_DECODE);
        step("sw.memadr", ST_MEMADR, O_MEMADR);
        mem_ready = 1'b0;
        repeat (3) step("sw.memwr_stall", ST_MEMWR, O_MEMWR);
        mem_ready = 1'b1;
        step("sw.memwr", ST_MEMWR, O_MEMWR);

        // R-type, BEQ, R-type; mem_ready low outside memory states is ignored
        op = OP_RTYPE;
        step("r1.fetch", ST_FETCH, O_FETCH);
        mem_ready = 1'b0;
        step("r1.decode", ST_DECODE, O_DECODE);
        step("r1.exec", ST_EXEC, O_EXEC);
        step("r1.aluwb", ST_ALUWB, O_ALUWB);
        mem_ready = 1'b1;
        op = OP_BEQ;
        step("beq.fetch", ST_FETCH, O_FETCH);
        step("beq.decode", ST_DECODE, O_DECODE);
        step("beq.branch", ST_BRANCH, O_BRANCH);
        op = OP_RTYPE;
        step("r2.fetch", ST_FETCH, O_FETCH);
        step("r2.decode", ST_DECODE, O_DECODE);
        step("r2.exec", ST_EXEC, O_EXEC);
        step("r2.aluwb", ST_ALUWB, O_ALUWB);
        check("r.count", m_count, 32'd5);

        // Illegal opcode, with a two-cycle fetch stall first
        op = opcode_type'(6'h3F);
        mem_ready = 1'b0;
        repeat (2) step("ill.fetch_stall", ST_FETCH, O_FSTALL);
        check("ill.stall_count", m_count, 32'd5);
        mem_ready = 1'b1;
        step("ill.fetch", ST_FETCH, O_FETCH);
        step("ill.decode", ST_DECODE, O_DECODE);
        step("ill.illegal", ST_ILLEGAL, O_ILL);
        check("ill.count", m_count, 32'd6);
        chk_m("ill.refetch", ST_FETCH, O_FETCH);

        // Counter wrap on the 4-bit instance: ten BEQs reach 16 fetches
        op = OP_BEQ;
        for (int i = 0; i < 10; i++) begin
            step("wrap.fetch", ST_FETCH, O_FETCH);
            step("wrap.decode", ST_DECODE, O_DECODE);
            step("wrap.branch", ST_BRANCH, O_BRANCH);
        end
        check("wrap.count16", m_count, 32'd16);
        check("wrap.w4_count16", {28'd0, w_count}, 32'd0);
        step("wrap.fetch17", ST_FETCH, O_FETCH);
        check("wrap.count17", m_count, 32'd17);
        check("wrap.w4_count17", {28'd0, w_count}, 32'd1);
        step("wrap.decode17", ST_DECODE, O_DECODE);
        step("wrap.branch17", ST_BRANCH, O_BRANCH);

        // Asynchronous reset during a MEMRD stall
        op = OP_LW;
        step("rrd.fetch", ST_FETCH, O_FETCH);
        step("rrd.decode", ST_DECODE, O_DECODE);
        step("rrd.memadr", ST_MEMADR, O_MEMADR);
        mem_ready = 1'b0;
        step("rrd.memrd_stall", ST_MEMRD, O_MEMRD);
        chk_m("rrd.memrd_stall2", ST_MEMRD, O_MEMRD);
        #2;
        rst_n = 1'b0;
        #1;
        check("rrd.state", {28'd0, m_state}, {28'd0, ST_IDLE});
        check("rrd.outs", {16'd0, m_outs}, 32'd0);
        check("rrd.count", m_count, 32'd0);
        check("rrd.w4_count", {28'd0, w_count}, 32'd0);
        tick();
        chk_m("rrd.held", ST_IDLE, O_NONE);

        // ILLEGAL_HALT=1 parks in ILLEGAL until reset
        op = opcode_type'(6'h3F);
        mem_ready = 1'b1;
        tick();
        rst_halt = 1'b1;
        step_h("halt.idle", ST_IDLE, O_NONE);
        step_h("halt.fetch", ST_FETCH, O_FETCH);
        step_h("halt.decode", ST_DECODE, O_DECODE);
        repeat (4) step_h("halt.park", ST_ILLEGAL, O_ILL);
        check("halt.count", h_count, 32'd1);
        #2;
        rst_halt = 1'b0;
        #1;
        check("halt.rst_state", {28'd0, h_state}, {28'd0, ST_IDLE});
        check("halt.rst_outs", {16'd0, h_outs}, 32'd0);
        check("halt.rst_count", h_count, 32'd0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
